filtro_comparador: RTL and testbench

Persistence filter and event counter placed directly downstream of the sequential 8-bit comparator. It consumes the comparator's registered 1-bit result `q` and suppresses glitches: the filtered output changes only after the raw input has held a new level for `N` consecutive clock cycles. It also emits one-cycle edge pulses and keeps a saturating count of confirmed rising events, for use by status and control logic.

---
 rtl/filtro_comparador_if.sv | 24 ++
 rtl/filtro_comparador.sv | 148 ++++++++++++++
 tb/tb_filtro_comparador.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/filtro_comparador_if.sv
// Bus of the persistence filter / event counter.
//   q_in, clr                       : driven by the producer (master)
//   q_filt, rise_pulse, fall_pulse,
//   n_eventos                       : driven by the filter (slave)
interface filtro_comparador_if #(
    parameter int CNT_W = 8
);
    logic             q_in;
    logic             clr;
    logic             q_filt;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] n_eventos;

    modport master (
        output q_in, clr,
        input  q_filt, rise_pulse, fall_pulse, n_eventos
    );

    modport slave (
        input  q_in, clr,
        output q_filt, rise_pulse, fall_pulse, n_eventos
    );
endinterface

// File: rtl/filtro_comparador.sv
// Persistence (glitch) filter for the registered comparator result.
// The filtered level changes only after q_in has held the new level for N
// consecutive clocks; confirmed edges raise one-cycle pulses and confirmed
// rises are counted in a saturating counter.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : filtro_comparador_if.slave (q_in, clr in; q_filt, rise_pulse,
//           fall_pulse, n_eventos out, all registered)
module filtro_comparador #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    filtro_comparador_if.slave  bus
);
    localparam int               CW       = $clog2(N + 1);
    localparam logic [CW-1:0]    N_C      = CW'(N);
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] EV_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EV_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] EV_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               N_ES_UNO = (N == 1);

    typedef enum logic [1:0] {
        BAJO      = 2'b00,
        PEND_ALTO = 2'b01,
        ALTO      = 2'b10,
        PEND_BAJO = 2'b11
    } estado_t;

    estado_t          state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [CW-1:0]    cnt_inc_s;
    logic             rise_s, fall_s;
    logic             q_filt_r, rise_pulse_r, fall_pulse_r;
    logic [CNT_W-1:0] n_eventos_r;

    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Next-state and run-counter logic; a broken run always restarts from zero.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        case (state_r)
            BAJO: begin
                if (bus.q_in) begin
                    if (N_ES_UNO) begin
                        state_s = ALTO;
                        cnt_s   = CNT_ZERO;
                        rise_s  = 1'b1;
                    end else begin
                        state_s = PEND_ALTO;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            PEND_ALTO: begin
                if (bus.q_in) begin
                    if (cnt_inc_s == N_C) begin
                        state_s = ALTO;
                        cnt_s   = CNT_ZERO;
                        rise_s  = 1'b1;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    state_s = BAJO;
                    cnt_s   = CNT_ZERO;
                end
            end
            ALTO: begin
                if (!bus.q_in) begin
                    if (N_ES_UNO) begin
                        state_s = BAJO;
                        cnt_s   = CNT_ZERO;
                        fall_s  = 1'b1;
                    end else begin
                        state_s = PEND_BAJO;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            PEND_BAJO: begin
                if (!bus.q_in) begin
                    if (cnt_inc_s == N_C) begin
                        state_s = BAJO;
                        cnt_s   = CNT_ZERO;
                        fall_s  = 1'b1;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    state_s = ALTO;
                    cnt_s   = CNT_ZERO;
                end
            end
            default: begin
                state_s = BAJO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State register, run counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= BAJO;
            cnt_r        <= CNT_ZERO;
            q_filt_r     <= 1'b0;
            rise_pulse_r <= 1'b0;
            fall_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            // q_filt is 1 in both "high" states (stable or pending low).
            q_filt_r     <= (state_s == ALTO) || (state_s == PEND_BAJO);
            rise_pulse_r <= rise_s;
            fall_pulse_r <= fall_s;
        end
    end

    // Saturating event counter; clr takes priority over a coincident rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_eventos_r <= EV_ZERO;
        end else if (bus.clr) begin
            n_eventos_r <= EV_ZERO;
        end else if (rise_s && (n_eventos_r != EV_MAX)) begin
            n_eventos_r <= n_eventos_r + EV_ONE;
        end else begin
            n_eventos_r <= n_eventos_r;
        end
    end

    assign bus.q_filt     = q_filt_r;
    assign bus.rise_pulse = rise_pulse_r;
    assign bus.fall_pulse = fall_pulse_r;
    assign bus.n_eventos  = n_eventos_r;
endmodule

// File: tb/tb_filtro_comparador.sv
// Self-checking bench: two instances (N=4/CNT_W=8 and N=1/CNT_W=2) driven by
// directed steps followed by random stimulus, compared every cycle against a
// run-length reference model.
module tb_filtro_comparador;
    logic clk = 1'b0;
    logic rst4, rst1;
    int   tests = 0;
    int   fails = 0;

    always #10 clk = ~clk;

    filtro_comparador_if #(.CNT_W(8)) b4 ();
    filtro_comparador_if #(.CNT_W(2)) b1 ();

    filtro_comparador #(.N(4), .CNT_W(8)) u4 (.clk(clk), .rst_n(rst4), .bus(b4.slave));
    filtro_comparador #(.N(1), .CNT_W(2)) u1 (.clk(clk), .rst_n(rst1), .bus(b1.slave));

    // Reference model state, index 0 -> u4, index 1 -> u1.
    int m_n   [2] = '{4, 1};
    int m_max [2] = '{255, 3};
    int m_filt[2];
    int m_run [2];
    int m_rise[2];
    int m_fall[2];
    int m_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: count consecutive samples differing
    // from the filtered level; flip after N of them.
    task automatic modelo(input int i, input logic r, input logic q, input logic c);
        if (!r) begin
            m_filt[i] = 0; m_run[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_cnt[i] = 0;
        end else begin
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (int'(q) != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == m_n[i]) begin
                    m_filt[i] = int'(q);
                    m_run[i]  = 0;
                    if (q) m_rise[i] = 1;
                    else   m_fall[i] = 1;
                end
            end else begin
                m_run[i] = 0;
            end
            if (c) m_cnt[i] = 0;
            else if (m_rise[i] == 1 && m_cnt[i] < m_max[i]) m_cnt[i]++;
        end
    endtask

    task automatic paso(input logic r4, input logic q4, input logic c4,
                        input logic r1, input logic q1, input logic c1);
        rst4 = r4; b4.q_in = q4; b4.clr = c4;
        rst1 = r1; b1.q_in = q1; b1.clr = c1;
        @(posedge clk);
        modelo(0, r4, q4, c4);
        modelo(1, r1, q1, c1);
        #1;
        chk("u4_q_filt", 32'(b4.q_filt),     32'(m_filt[0]));
        chk("u4_rise",   32'(b4.rise_pulse), 32'(m_rise[0]));
        chk("u4_fall",   32'(b4.fall_pulse), 32'(m_fall[0]));
        chk("u4_n_ev",   32'(b4.n_eventos),  32'(m_cnt[0]));
        chk("u1_q_filt", 32'(b1.q_filt),     32'(m_filt[1]));
        chk("u1_rise",   32'(b1.rise_pulse), 32'(m_rise[1]));
        chk("u1_fall",   32'(b1.fall_pulse), 32'(m_fall[1]));
        chk("u1_n_ev",   32'(b1.n_eventos),  32'(m_cnt[1]));
        chk("u4_excl",   32'(b4.rise_pulse & b4.fall_pulse), 32'd0);
    endtask

    initial begin
        logic q4, q1, r4, r1, c4, c1;
        // Reset held 2 cycles with q_in=1; u1 stays in reset during the N=4 part.
        paso(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        paso(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_q_filt", 32'(b4.q_filt), 32'd0);
        chk("rst_n_ev",   32'(b4.n_eventos), 32'd0);
        // Release with q_in=1: glitch of 3 samples, then 0.
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rel_q_filt", 32'(b4.q_filt), 32'd0);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        paso(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("glitch_q_filt", 32'(b4.q_filt), 32'd0);
        chk("glitch_n_ev",   32'(b4.n_eventos), 32'd0);
        // Confirmed rise: 4 samples high.
        for (int k = 0; k < 3; k++) paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rise_q", 32'(b4.q_filt), 32'd0);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rise_q",    32'(b4.q_filt), 32'd1);
        chk("rise_p",    32'(b4.rise_pulse), 32'd1);
        chk("rise_n_ev", 32'(b4.n_eventos), 32'd1);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rise_p_end", 32'(b4.rise_pulse), 32'd0);
        // Low glitch of one sample, then confirmed fall.
        paso(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lglitch_q", 32'(b4.q_filt), 32'd1);
        for (int k = 0; k < 3; k++) paso(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_fall_q", 32'(b4.q_filt), 32'd1);
        paso(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fall_q",    32'(b4.q_filt), 32'd0);
        chk("fall_p",    32'(b4.fall_pulse), 32'd1);
        chk("fall_n_ev", 32'(b4.n_eventos), 32'd1);
        paso(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fall_p_end", 32'(b4.fall_pulse), 32'd0);
        // Reset in the middle of a pending run.
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        paso(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_q3", 32'(b4.q_filt), 32'd0);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_q4", 32'(b4.q_filt), 32'd1);

        // N=1, CNT_W=2: saturation then clr coincident with a rise.
        paso(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            paso(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("sat_rise", 32'(b1.rise_pulse), 32'd1);
            chk("sat_n_ev", 32'(b1.n_eventos), 32'((k < 3) ? k : 3));
            paso(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("n1_fall", 32'(b1.fall_pulse), 32'd1);
        end
        paso(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_rise_p", 32'(b1.rise_pulse), 32'd1);
        chk("clr_rise_n", 32'(b1.n_eventos), 32'd0);
        chk("clr_rise_q", 32'(b1.q_filt), 32'd1);

        // Random phase: sticky q_in so runs of N and more occur frequently.
        q4 = 1'b0; q1 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) q4 = ~q4;
            if ($urandom_range(0, 1) == 0) q1 = ~q1;
            r4 = ($urandom_range(0, 63) != 0);
            r1 = ($urandom_range(0, 63) != 0);
            c4 = ($urandom_range(0, 15) == 0);
            c1 = ($urandom_range(0, 15) == 0);
            paso(r4, q4, c4, r1, q1, c1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
